runner_game_ctrl: RTL and testbench

- Game sequencer for the six-digit runner display. Owns the obstacle field, the player lane, the score and the login, play, crash and score phases.
- Drives the display decoder's loggedIn, ceilingBits, floorBits, playerPos, score and showScore inputs.
- Advances one game step per tick strobe.
- Obstacles enter at column 0 (rightmost) and travel toward column 5. The player sits in column 4.

---
 rtl/game_pkg.sv | 24 ++
 rtl/runner_game_ctrl_if.sv | 31 +++
 rtl/runner_lfsr.sv | 29 ++
 rtl/runner_game_ctrl.sv | 174 +++++++++++++++++
 tb/tb_runner_game_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the runner game sequencer: state encoding,
// lane codes, field geometry and the obstacle LFSR step function.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        CRASH = 2'd2,
        SCORE = 2'd3
    } game_state_t;

    localparam logic LANE_FLOOR = 1'b0;
    localparam logic LANE_CEIL  = 1'b1;

    localparam int NUM_COLS   = 6;
    localparam int PLAYER_COL = 4;
    localparam int SCORE_W    = 14;

    // Fibonacci step, taps 8,6,5,4 counted from the input end (bit7 = stage 1).
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[4], v[7:1]};
    endfunction

endpackage

// File: rtl/runner_game_ctrl_if.sv
// Signal bundle between the game sequencer and its surroundings (buttons,
// tick source, auth block on one side, display decoder on the other).
interface runner_game_ctrl_if;
    import game_pkg::*;

    logic                loggedIn_in;
    logic                tick;
    logic                startBtn;
    logic                flipBtn;
    logic                spawnEn;
    logic                injEn;
    logic                injLane;
    logic                loggedIn;
    logic [NUM_COLS-1:0] ceilingBits;
    logic [NUM_COLS-1:0] floorBits;
    logic                playerPos;
    logic [SCORE_W-1:0]  score;
    logic                showScore;
    logic [1:0]          state_o;

    modport master (
        output loggedIn_in, tick, startBtn, flipBtn, spawnEn, injEn, injLane,
        input  loggedIn, ceilingBits, floorBits, playerPos, score, showScore, state_o
    );

    modport slave (
        input  loggedIn_in, tick, startBtn, flipBtn, spawnEn, injEn, injLane,
        output loggedIn, ceilingBits, floorBits, playerPos, score, showScore, state_o
    );

endinterface

// File: rtl/runner_lfsr.sv
// 8-bit obstacle LFSR with seed reload and step enable; exposes only the two
// bits the spawner draws from (bit0 = spawn decision, bit1 = lane).
module runner_lfsr
    import game_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    output logic [1:0] draw
);

    logic [7:0] lfsr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= SEED;
        end else if (load) begin
            lfsr_reg <= SEED;
        end else if (step) begin
            lfsr_reg <= lfsr_next(lfsr_reg);
        end
    end

    assign draw = lfsr_reg[1:0];

endmodule

// File: rtl/runner_game_ctrl.sv
// Runner game sequencer: owns obstacle field, player lane and score, and walks
// the IDLE/PLAY/CRASH/SCORE phases one step per tick strobe.
module runner_game_ctrl
    import game_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    parameter int         MIN_GAP     = 2,
    parameter int         CRASH_TICKS = 3,
    parameter int         SCORE_MAX   = 9999
) (
    input logic              clk,
    input logic              rst_n,
    runner_game_ctrl_if.slave bus
);

    localparam logic [7:0]         GAP_SAT    = 8'(MIN_GAP);
    localparam logic [7:0]         CRASH_LAST = 8'(CRASH_TICKS - 1);
    localparam logic [SCORE_W-1:0] SCORE_TOP  = SCORE_W'(SCORE_MAX);

    game_state_t         state_reg, state_next;
    logic [NUM_COLS-1:0] ceil_reg, ceil_next, floor_reg, floor_next;
    logic [NUM_COLS-1:0] ceil_stepped, floor_stepped;
    logic                pos_reg, pos_next, pend_reg, pend_next;
    logic [SCORE_W-1:0]  score_reg, score_next;
    logic [7:0]          gap_reg, gap_next, crash_cnt_reg, crash_cnt_next;
    logic                login_reg, show_reg;
    logic                lfsr_load, lfsr_step;
    logic [1:0]          lfsr_draw;
    logic                flip_now, pos_stepped, spawn_ok, ins_valid, ins_lane, hit;

    runner_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .draw  (lfsr_draw)
    );

    // Candidate field/lane after one PLAY tick; committed only when a tick lands in PLAY.
    assign flip_now    = pend_reg | bus.flipBtn;
    assign pos_stepped = pos_reg ^ flip_now;
    assign spawn_ok    = bus.spawnEn && (gap_reg >= GAP_SAT) && lfsr_draw[0];
    assign ins_valid   = bus.injEn | spawn_ok;
    assign ins_lane    = bus.injEn ? bus.injLane : lfsr_draw[1];

    assign ceil_stepped[0]  = ins_valid && (ins_lane == LANE_CEIL);
    assign floor_stepped[0] = ins_valid && (ins_lane == LANE_FLOOR);
    genvar gi;
    generate
        for (gi = 1; gi < NUM_COLS; gi++) begin : g_shift
            assign ceil_stepped[gi]  = ceil_reg[gi-1];
            assign floor_stepped[gi] = floor_reg[gi-1];
        end
    endgenerate

    assign hit = (pos_stepped == LANE_CEIL) ? ceil_stepped[PLAYER_COL]
                                            : floor_stepped[PLAYER_COL];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!bus.loggedIn_in) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (bus.startBtn) state_next = PLAY;
                PLAY:    if (bus.tick && hit) state_next = CRASH;
                CRASH:   if (bus.tick && (crash_cnt_reg == CRASH_LAST)) state_next = SCORE;
                SCORE:   if (bus.startBtn) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        ceil_next      = ceil_reg;
        floor_next     = floor_reg;
        pos_next       = pos_reg;
        score_next     = score_reg;
        pend_next      = pend_reg;
        gap_next       = gap_reg;
        crash_cnt_next = crash_cnt_reg;
        lfsr_load      = 1'b0;
        lfsr_step      = 1'b0;
        if (!bus.loggedIn_in) begin
            ceil_next  = '0;
            floor_next = '0;
            pos_next   = 1'b0;
            score_next = '0;
            pend_next  = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.startBtn) begin
                        lfsr_load = 1'b1;
                        gap_next  = GAP_SAT;
                        pend_next = 1'b0;
                    end
                end
                PLAY: begin
                    if (bus.tick) begin
                        pos_next   = pos_stepped;
                        pend_next  = 1'b0;
                        ceil_next  = ceil_stepped;
                        floor_next = floor_stepped;
                        gap_next   = ins_valid ? 8'd0
                                   : ((gap_reg < GAP_SAT) ? gap_reg + 8'd1 : GAP_SAT);
                        lfsr_step  = 1'b1;
                        if (hit) begin
                            crash_cnt_next = 8'd0;
                        end else begin
                            score_next = (score_reg >= SCORE_TOP) ? SCORE_TOP
                                                                  : score_reg + 1'b1;
                        end
                    end else begin
                        pend_next = flip_now;
                    end
                end
                CRASH: begin
                    pend_next = 1'b0;
                    if (bus.tick) crash_cnt_next = crash_cnt_reg + 8'd1;
                end
                SCORE: begin
                    if (bus.startBtn) begin
                        ceil_next  = '0;
                        floor_next = '0;
                        score_next = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ceil_reg      <= '0;
            floor_reg     <= '0;
            pos_reg       <= 1'b0;
            score_reg     <= '0;
            pend_reg      <= 1'b0;
            gap_reg       <= GAP_SAT;
            crash_cnt_reg <= 8'd0;
            login_reg     <= 1'b0;
            show_reg      <= 1'b0;
        end else begin
            ceil_reg      <= ceil_next;
            floor_reg     <= floor_next;
            pos_reg       <= pos_next;
            score_reg     <= score_next;
            pend_reg      <= pend_next;
            gap_reg       <= gap_next;
            crash_cnt_reg <= crash_cnt_next;
            login_reg     <= bus.loggedIn_in;
            show_reg      <= (state_next == SCORE);
        end
    end

    assign bus.loggedIn    = login_reg;
    assign bus.ceilingBits = ceil_reg;
    assign bus.floorBits   = floor_reg;
    assign bus.playerPos   = pos_reg;
    assign bus.score       = score_reg;
    assign bus.showScore   = show_reg;
    assign bus.state_o     = state_reg;

endmodule

// File: tb/tb_runner_game_ctrl.sv
// Self-checking bench for runner_game_ctrl: directed scenarios plus randomized
// play, compared every cycle against a behavioural game model.
module tb_runner_game_ctrl;

    localparam int         MIN_GAP     = 2;
    localparam int         CRASH_TICKS = 3;
    localparam int         SCORE_MAX   = 9999;
    localparam int         SCORE_MAX_B = 5;
    localparam logic [7:0] SEED        = 8'hA5;
    localparam int         RUN_TICKS   = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic li = 1'b0, tick = 1'b0, start = 1'b0, flip = 1'b0;
    logic spawn = 1'b0, inj = 1'b0, injl = 1'b0;

    always #5 clk = ~clk;

    runner_game_ctrl_if bus_a ();
    runner_game_ctrl_if bus_b ();

    assign bus_a.loggedIn_in = li;
    assign bus_a.tick        = tick;
    assign bus_a.startBtn    = start;
    assign bus_a.flipBtn     = flip;
    assign bus_a.spawnEn     = spawn;
    assign bus_a.injEn       = inj;
    assign bus_a.injLane     = injl;
    assign bus_b.loggedIn_in = li;
    assign bus_b.tick        = tick;
    assign bus_b.startBtn    = start;
    assign bus_b.flipBtn     = flip;
    assign bus_b.spawnEn     = spawn;
    assign bus_b.injEn       = inj;
    assign bus_b.injLane     = injl;

    runner_game_ctrl #(.LFSR_SEED(SEED), .MIN_GAP(MIN_GAP), .CRASH_TICKS(CRASH_TICKS),
                       .SCORE_MAX(SCORE_MAX)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    runner_game_ctrl #(.LFSR_SEED(SEED), .MIN_GAP(MIN_GAP), .CRASH_TICKS(CRASH_TICKS),
                       .SCORE_MAX(SCORE_MAX_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    // Game model: 0 idle, 1 play, 2 crash, 3 score; columns as arrays, index = column.
    int         m_state, m_score, m_gap, m_crash;
    bit         m_ceil[6], m_floor[6];
    bit         m_pos, m_pend, m_login;
    bit [7:0]   m_lfsr;
    int         n_vec = 0, n_err = 0;
    bit [1:0]   q_run1[$], q_run2[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] pack(input bit a[6]);
        logic [5:0] v;
        for (int c = 0; c < 6; c++) v[c] = a[c];
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_score = 0; m_gap = MIN_GAP; m_crash = 0;
        m_ceil = '{default: 0}; m_floor = '{default: 0};
        m_pos = 0; m_pend = 0; m_login = 0; m_lfsr = SEED;
    endtask

    task automatic model_clock();
        bit nc, nf, fb, hit;
        m_login = li;
        if (!li) begin
            m_state = 0; m_score = 0; m_pos = 0; m_pend = 0;
            m_ceil = '{default: 0}; m_floor = '{default: 0};
            return;
        end
        case (m_state)
            0: if (start) begin m_state = 1; m_lfsr = SEED; m_gap = MIN_GAP; m_pend = 0; end
            1: begin
                if (flip) m_pend = 1;
                if (tick) begin
                    if (m_pend) begin m_pos = !m_pos; m_pend = 0; end
                    for (int c = 5; c > 0; c--) begin
                        m_ceil[c] = m_ceil[c-1]; m_floor[c] = m_floor[c-1];
                    end
                    nc = 0; nf = 0;
                    if (inj) begin
                        if (injl) nc = 1; else nf = 1;
                    end else if (spawn && m_gap >= MIN_GAP && m_lfsr[0]) begin
                        if (m_lfsr[1]) nc = 1; else nf = 1;
                    end
                    m_ceil[0] = nc; m_floor[0] = nf;
                    if (nc || nf) m_gap = 0; else if (m_gap < MIN_GAP) m_gap++;
                    fb = ($countones(m_lfsr & 8'h1D) % 2) == 1;
                    m_lfsr = {fb, m_lfsr[7:1]};
                    hit = m_pos ? m_ceil[4] : m_floor[4];
                    if (hit) begin m_state = 2; m_crash = 0; end
                    else if (m_score < SCORE_MAX) m_score++;
                end
            end
            2: begin
                m_pend = 0;
                if (tick) begin m_crash++; if (m_crash == CRASH_TICKS) m_state = 3; end
            end
            default: if (start) begin
                m_state = 0; m_score = 0;
                m_ceil = '{default: 0}; m_floor = '{default: 0};
            end
        endcase
    endtask

    task automatic compare_all();
        chk("state",     bus_a.state_o,     m_state);
        chk("loggedIn",  bus_a.loggedIn,    m_login);
        chk("ceiling",   bus_a.ceilingBits, pack(m_ceil));
        chk("floor",     bus_a.floorBits,   pack(m_floor));
        chk("playerPos", bus_a.playerPos,   m_pos);
        chk("score",     bus_a.score,       m_score);
        chk("showScore", bus_a.showScore,   m_state == 3);
        chk("scoreSat",  bus_b.score,       (m_score < SCORE_MAX_B) ? m_score : SCORE_MAX_B);
        chk("stateB",    bus_b.state_o,     m_state);
        chk("bothLanes", bus_a.ceilingBits & bus_a.floorBits, 0);
    endtask

    task automatic step(input bit t, input bit s, input bit f, input bit sp,
                        input bit ij, input bit ijl);
        @(negedge clk);
        tick = t; start = s; flip = f; spawn = sp; inj = ij; injl = ijl;
        @(posedge clk);
        model_clock();
        #1;
        compare_all();
        $display("t=%0t tick=%0b start=%0b flip=%0b inj=%0b/%0b -> state=%0d ceil=%b floor=%b pos=%0b score=%0d",
                 $time, t, s, f, ij, ijl, bus_a.state_o, bus_a.ceilingBits, bus_a.floorBits,
                 bus_a.playerPos, bus_a.score);
    endtask

    // Random spawn run with a dodging player; records the column-0 entry of every tick.
    task automatic run_spawn(input bit second);
        int  last_ins = -100;
        bit  need, safe, do_flip;
        for (int i = 0; i < RUN_TICKS; i++) begin
            need    = m_pos ? m_ceil[3] : m_floor[3];
            safe    = !m_ceil[3] && !m_floor[3];
            do_flip = need || (safe && ($urandom_range(3) == 0));
            if ($urandom_range(1) == 0) begin
                step(0, 0, do_flip, 1, 0, 0);
                step(1, 0, 0, 1, 0, 0);
            end else begin
                step(1, 0, do_flip, 1, 0, 0);
            end
            if (second) q_run2.push_back({bus_a.ceilingBits[0], bus_a.floorBits[0]});
            else        q_run1.push_back({bus_a.ceilingBits[0], bus_a.floorBits[0]});
            if (bus_a.ceilingBits[0] || bus_a.floorBits[0]) begin
                chk("spawnGap", (i - last_ins) > MIN_GAP, 1);
                last_ins = i;
            end
        end
    endtask

    initial begin
        int pre, spawned;
        model_reset();
        repeat (2) @(posedge clk);
        #1 compare_all();
        @(negedge clk) rst_n = 1'b1;

        step(0, 1, 0, 0, 0, 0);
        chk("startNoLogin", bus_a.state_o, 0);
        li = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("startPlay", bus_a.state_o, 1);

        step(1, 0, 0, 0, 1, 1);
        chk("travel0", bus_a.ceilingBits, 6'b000001);
        step(1, 0, 0, 0, 0, 0);
        chk("travel1", bus_a.ceilingBits, 6'b000010);
        step(1, 0, 0, 0, 0, 0);
        chk("travel2", bus_a.ceilingBits, 6'b000100);
        step(1, 0, 0, 0, 0, 0);
        chk("travel3", bus_a.ceilingBits, 6'b001000);
        chk("travelScore", bus_a.score, 4);

        step(1, 0, 0, 0, 1, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0);
        pre = m_score;
        step(1, 0, 0, 0, 0, 0);
        chk("crashFloor", bus_a.floorBits, 6'b010000);
        chk("crashState", bus_a.state_o, 2);
        chk("crashScore", bus_a.score, pre);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0);
        chk("scoreState", bus_a.state_o, 3);
        chk("scoreShow", bus_a.showScore, 1);
        chk("scoreHeld", bus_a.score, pre);
        step(0, 1, 0, 0, 0, 0);
        chk("restartIdle", bus_a.state_o, 0);
        chk("restartScore", bus_a.score, 0);

        step(1, 1, 0, 0, 0, 0);
        chk("startWithTick", bus_a.ceilingBits | bus_a.floorBits, 0);
        step(1, 0, 0, 0, 1, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        chk("dodgePos", bus_a.playerPos, 1);
        chk("dodgeState", bus_a.state_o, 1);
        chk("dodgeScore", bus_a.score, 5);
        repeat (10) step(1, 0, 0, 0, 0, 0);
        chk("satHold", bus_b.score, 5);

        li = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        chk("logoutClear", bus_a.score, 0);
        li = 1'b1;
        step(0, 1, 0, 0, 0, 0);
        run_spawn(1'b0);

        step(1, 0, 0, 0, 1, m_pos);
        for (int i = 0; i < 10 && m_state != 2; i++) step(1, 0, 0, 0, 0, 0);
        chk("forcedCrash", bus_a.state_o, 2);
        repeat (CRASH_TICKS) step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        run_spawn(1'b1);
        spawned = 0;
        for (int i = 0; i < RUN_TICKS; i++) begin
            chk("replay", q_run2[i], q_run1[i]);
            if (q_run1[i] != 2'b00) spawned++;
        end
        chk("spawnedSome", spawned > 0, 1);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rstState", bus_a.state_o, 0);
        chk("rstField", {bus_a.ceilingBits, bus_a.floorBits}, 0);
        chk("rstScore", bus_a.score, 0);
        chk("rstMisc", {bus_a.loggedIn, bus_a.playerPos, bus_a.showScore}, 0);
        @(negedge clk) rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
